// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Holds the sweep/run state type and the default sizes used by the core.
// No logic; imported by regfile_mp and regfile_scoreboard.
package regfile_pkg;

  typedef enum logic {
    RF_SWEEP = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a register busy, writeback clears it.
// Latency: busy bits update at posedge; lookups are combinational (0 cycles).
// Backpressure: none; issue and clear are accepted every cycle while run=1.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] lk_addr,
  output logic [NRD-1:0]    lk_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NRD-1:0]   lk_hit;

  // Next busy vector: clears first, then the issue mark so a newer producer wins.
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (iss_en && !(ZERO_REG != 0 && iss_rd == '0)) busy_nxt[iss_rd] = 1'b1;
    end
  end

  // Busy bit storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Lookup: a same-cycle clearing write hides the busy bit unless re-issued now.
  always_comb begin
    lk_hit  = '0;
    lk_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == lk_addr[i*AW +: AW]) lk_hit[i] = 1'b1;
      end
      lk_busy[i] = run && busy[lk_addr[i*AW +: AW]];
      if (BYPASS != 0 && lk_hit[i] && !(iss_en && iss_rd == lk_addr[i*AW +: AW]))
        lk_busy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write->read bypass, busy scoreboard and post-reset clear sweep.
// Latency: reads 0 cycles (combinational); writes land at posedge; ready after NREGS sweep cycles.
// Backpressure: none; writes and issues are dropped while ready=0.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_t       state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] regs [NREGS];
  logic            run;

  assign run   = (state == RF_RUN);
  assign ready = run;

  // Sweep FSM: clear one entry per cycle, stop at the last one without wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RF_SWEEP;
      ptr   <= '0;
    end else if (state == RF_SWEEP) begin
      if (ptr == LAST) state <= RF_RUN;
      else             ptr   <= ptr + 1'b1;
    end
  end

  // Array update: sweep clear, else the write ports in ascending order so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == RF_SWEEP) begin
        regs[ptr] <= '0;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0))
            regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Read muxes: array, overridden by the highest matching same-cycle write, zeroed for x0 and sweep.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW])
            rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
        end
      end
      if (!run || (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0))
        rd_data[i*XLEN +: XLEN] = '0;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .lk_addr (rd_addr),
    .lk_busy (rd_busy)
  );

endmodule
